// File: rtl/multicycle_lsu.sv
// Multicycle load/store unit: one outstanding access, byte/word sizes, registered outputs.
// Optional ISSUE-phase abort timer is compiled in when LSU_TIMEOUT_EN is defined.
module multicycle_lsu #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            o_dbg_state
);

  localparam int NBE    = DATA_W / 8;
  localparam int LANE_W = (NBE > 1) ? $clog2(NBE) : 1;

  // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
  // a response transfers on the rising edge where rsp_valid && rsp_ready. Neither
  // valid depends combinationally on its ready, and ready is only high in the
  // state that can take the transfer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_write;
  logic              r_size;
  logic              r_signed;
  logic [LANE_W-1:0] r_lane;

  logic [LANE_W-1:0] w_req_lane;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_word_addr;
  logic [NBE-1:0]    w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_lane_byte;
  logic [DATA_W-1:0] w_load_data;
  logic              w_accept;
  logic              w_tmo_expire;

  assign w_req_lane   = req_addr[LANE_W-1:0];
  assign w_misaligned = req_size && (w_req_lane != '0);
  assign w_word_addr  = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign w_accept     = req_valid && req_ready;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_be    = '1;
    w_wdata = req_wdata;
    if (!req_size) begin
      w_be    = NBE'(1) << w_req_lane;
      w_wdata = {NBE{req_wdata[7:0]}};
    end
  end

  always_comb begin
    w_lane_byte = mem_rdata[7:0];
    for (int i = 0; i < NBE; i++) begin
      if (r_lane == LANE_W'(i)) begin
        w_lane_byte = mem_rdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_load_data = '0;
    if (!r_write) begin
      if (r_size) begin
        w_load_data = mem_rdata;
      end else if (r_signed) begin
        w_load_data = {{(DATA_W-8){w_lane_byte[7]}}, w_lane_byte};
      end else begin
        w_load_data = {{(DATA_W-8){1'b0}}, w_lane_byte};
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] r_tmo_cnt;
  // Counter holds the number of completed ISSUE cycles; expiry fires on the last one.
  assign w_tmo_expire = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_tmo_expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_size    <= 1'b0;
      r_signed  <= 1'b0;
      r_lane    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write   <= req_write;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_lane    <= w_req_lane;
            req_ready <= 1'b0;
            if (w_misaligned) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state   <= ST_ISSUE;
              mem_addr  <= w_word_addr;
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
              mem_we    <= req_write;
              mem_re    <= !req_write;
`ifdef LSU_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            r_state   <= ST_RESP;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= w_load_data;
          end else if (w_tmo_expire) begin
            r_state   <= ST_RESP;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
`endif
          end
        end
        ST_RESP: begin
          // Returning to IDLE takes a cycle, so no request is taken on the consume edge.
          if (rsp_ready) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_lsu.sv
// Self-checking bench for multicycle_lsu: directed vectors plus randomized traffic
// against an arithmetic reference model and an expected-response queue.
module tb_multicycle_lsu;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int NB  = DW / 8;
  localparam int TMO = 4;

  logic          clock;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_be;
  logic          mem_we;
  logic          mem_re;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  multicycle_lsu #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;
  } exp_t;

  logic [DW:0] exp_q[$];

  logic [AW-1:0] obs_addr;
  logic [NB-1:0] obs_be;
  logic [DW-1:0] obs_wdata;
  logic          obs_we;
  logic          obs_re;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  int            obs_lat;

  // reference model: what the unit should do, from address arithmetic alone
  function automatic exp_t model(input logic wr, input logic sz, input logic sg,
                                 input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] rd);
    exp_t e;
    int   lane;
    int   b;
    e    = '0;
    lane = int'(a) % NB;
    e.addr = a - AW'(lane);
    if (sz && lane != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.we = wr;
    e.re = !wr;
    if (sz) begin
      e.be    = '1;
      e.wdata = wd;
    end else begin
      e.be = '0;
      e.be[lane] = 1'b1;
      for (int k = 0; k < NB; k++) e.wdata[8*k +: 8] = wd[7:0];
    end
    if (!wr) begin
      if (sz) begin
        e.rdata = rd;
      end else begin
        b = int'(rd[8*lane +: 8]);
        if (sg && b >= 128) b = b - 256;
        e.rdata = DW'(b);
      end
    end
    return e;
  endfunction

  // driver: one full transaction with inline checks of issue, latency and response
  task automatic do_txn(input logic wr, input logic sz, input logic sg,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int ack_delay, input int rsp_delay);
    exp_t        e;
    logic [DW:0] exp_rsp;
    int          lat;
    e = model(wr, sz, sg, a, wd, rd);
    exp_q.push_back({e.err, e.rdata});
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
    obs_we = mem_we; obs_re = mem_re;
    n_checks++;
    if ({mem_re, mem_we} !== {e.re, e.we}) begin
      n_fail++; $display("FAIL strobes_issue: got re/we %b%b expected %b%b", mem_re, mem_we, e.re, e.we);
    end
    if (!e.err) begin
      n_checks++;
      if ({mem_addr, mem_be, mem_wdata} !== {e.addr, e.be, e.wdata}) begin
        n_fail++;
        $display("FAIL issue_fields: got addr=%h be=%b wdata=%h expected addr=%h be=%b wdata=%h",
                 mem_addr, mem_be, mem_wdata, e.addr, e.be, e.wdata);
      end
      for (int d = 0; d < ack_delay; d++) begin
        mem_ack = (d % 2 == 1) ? 1'b0 : 1'b0;
        mem_rdata = DW'($urandom);
        @(negedge clock);
        lat++;
        n_checks++;
        if ({mem_re, mem_we, mem_addr, mem_be, mem_wdata} !== {e.re, e.we, e.addr, e.be, e.wdata}) begin
          n_fail++; $display("FAIL issue_hold: cycle %0d got re=%b we=%b addr=%h expected re=%b we=%b addr=%h",
                             d, mem_re, mem_we, mem_addr, e.re, e.we, e.addr);
        end
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clock);
      lat++;
      mem_ack = 1'b0; mem_rdata = DW'($urandom);
    end
    for (int w = 0; w < 8 && rsp_valid !== 1'b1; w++) begin
      @(negedge clock);
      lat++;
    end
    obs_lat = lat;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rsp_timeout: rsp_valid=%b not seen within bound", rsp_valid);
    end
    n_checks++;
    if (lat !== (e.err ? 1 : ack_delay + 2)) begin
      n_fail++; $display("FAIL rsp_latency: got %0d expected %0d", lat, e.err ? 1 : ack_delay + 2);
    end
    n_checks++;
    if ({mem_re, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL strobes_resp: got re/we %b%b expected 00", mem_re, mem_we);
    end
    for (int h = 0; h < rsp_delay; h++) begin
      @(negedge clock);
      n_checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp_q[0]}) begin
        n_fail++; $display("FAIL rsp_hold: got valid=%b ready=%b err=%b rdata=%h expected 1 0 %b %h",
                           rsp_valid, req_ready, rsp_err, rsp_rdata, exp_q[0][DW], exp_q[0][DW-1:0]);
      end
    end
    obs_rdata = rsp_rdata; obs_err = rsp_err;
    rsp_ready = 1'b1;
    exp_rsp = exp_q.pop_front();
    n_checks++;
    if ({rsp_err, rsp_rdata} !== exp_rsp) begin
      n_fail++; $display("FAIL rsp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                         rsp_err, rsp_rdata, exp_rsp[DW], exp_rsp[DW-1:0]);
    end
    @(negedge clock);
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL back_to_idle: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_we, mem_re, mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%b err=%b rdata=%h we=%b re=%b be=%b addr=%h wdata=%h expected all 0",
                         rsp_valid, rsp_err, rsp_rdata, mem_we, mem_re, mem_be, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_word_load();
    do_txn(1'b0, 1'b1, 1'b0, 16'h0010, DW'($urandom), 16'hBEEF, 0, 0);
    n_checks++;
    if ({obs_re, obs_be, obs_rdata, obs_err} !== {1'b1, 2'b11, 16'hBEEF, 1'b0} || obs_lat != 2) begin
      n_fail++; $display("FAIL word_load: got re=%b be=%b rdata=%h err=%b lat=%0d expected 1 11 beef 0 2",
                         obs_re, obs_be, obs_rdata, obs_err, obs_lat);
    end
  endtask

  task automatic test_byte_load();
    do_txn(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 16'h80AA, 1, 0);
    n_checks++;
    if ({obs_addr, obs_be, obs_rdata} !== {16'h0020, 2'b10, 16'hFF80}) begin
      n_fail++; $display("FAIL byte_load_signed: got addr=%h be=%b rdata=%h expected 0020 10 ff80",
                         obs_addr, obs_be, obs_rdata);
    end
    do_txn(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h80AA, 0, 0);
    n_checks++;
    if (obs_rdata !== 16'h0080) begin
      n_fail++; $display("FAIL byte_load_unsigned: got %h expected 0080", obs_rdata);
    end
  endtask

  task automatic test_byte_store();
    do_txn(1'b1, 1'b0, 1'b0, 16'h0003, 16'h1234, 16'hFFFF, 0, 0);
    n_checks++;
    if ({obs_we, obs_be, obs_wdata, obs_rdata} !== {1'b1, 2'b10, 16'h3434, 16'h0000}) begin
      n_fail++; $display("FAIL byte_store: got we=%b be=%b wdata=%h rdata=%h expected 1 10 3434 0000",
                         obs_we, obs_be, obs_wdata, obs_rdata);
    end
  endtask

  task automatic test_misaligned();
    do_txn(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1111, 0, 0);
    n_checks++;
    if ({obs_re, obs_we, obs_err, obs_rdata} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL misaligned: got re=%b we=%b err=%b rdata=%h expected 0 0 1 0000",
                         obs_re, obs_we, obs_err, obs_rdata);
    end
    do_txn(1'b1, 1'b1, 1'b0, 16'h7FFF, 16'hA5A5, 16'h0000, 0, 1);
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 1'b1, 1'b0, 16'h0102, 16'h0000, 16'h5A3C, 2, 5);
  endtask

  task automatic test_stray_ack();
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    repeat (2) @(negedge clock);
    mem_ack = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({rsp_valid, req_ready, mem_re, mem_we} !== 4'b0100) begin
      n_fail++; $display("FAIL stray_ack: got valid=%b ready=%b re=%b we=%b expected 0 1 0 0",
                         rsp_valid, req_ready, mem_re, mem_we);
    end
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 16'h0040; req_wdata = 16'hCAFE;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++; $display("FAIL mid_issue_pre: got we=%b expected 1", mem_we);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_re, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL async_strobe_drop: got re/we %b%b expected 00", mem_re, mem_we);
    end
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_abandon: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
    int hi;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_addr = 16'h0080;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    hi = 0;
    for (int c = 0; c < 20 && mem_re === 1'b1; c++) begin
      hi++;
      @(negedge clock);
    end
    n_checks++;
    if (hi != TMO) begin
      n_fail++; $display("FAIL timeout_strobe_len: got %0d cycles expected %0d", hi, TMO);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL timeout_rsp: got valid=%b err=%b rdata=%h expected 1 1 0000",
                         rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    do_txn(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h1357, TMO - 1, 0);
    n_checks++;
    if (obs_err !== 1'b0) begin
      n_fail++; $display("FAIL ack_wins_expiry: got err=%b expected 0", obs_err);
    end
`else
    do_txn(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h1357, 40, 0);
`endif
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int t = 0; t < 60; t++) begin
      a = AW'($urandom);
      do_txn(1'($urandom), 1'($urandom), 1'($urandom), a, DW'($urandom), DW'($urandom),
             $urandom_range(0, TMO - 1), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_backpressure();
    test_stray_ack();
    test_reset_mid_issue();
    test_timeout();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
